// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the byte-wide BRAM word arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package bram_arb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int K_W            = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is the instruction port, bit 1 the data port.
// last_grant records the winner on each update strobe and steers the next tie.
module bram_rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output grant_e     last_grant
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_INST) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_DATA;
    end else if (update && (|gnt)) begin
      last_grant <= gnt[1] ? GNT_DATA : GNT_INST;
    end
  end

endmodule

// File: rtl/bram_word_arbiter.sv
// Shares a single-port byte-wide BRAM between an instruction-fetch port and a
// data port; each 32-bit access is four little-endian byte cycles.
module bram_word_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-3:0] i_addr,
  output logic                  i_ack,
  output logic [WORD_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-3:0] d_addr,
  input  logic [WORD_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [WORD_W-1:0]     d_rdata,
  output logic                  busy,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  input  logic [DATA_WIDTH-1:0] bram_douta
);

  localparam int                WA_W   = ADDR_WIDTH - 2;
  localparam logic [K_W-1:0]    K_LAST = K_W'(BYTES_PER_WORD - 1);

  if (DATA_WIDTH != 8) begin : g_data_width_check
    $error("bram_word_arbiter: DATA_WIDTH must be 8");
  end

  state_e                  state, state_nx;
  logic [K_W-1:0]          k, k_nx, k_inc;
  logic [1:0]              gnt;
  grant_e                  last_grant;
  logic                    arb_update;

  logic [WA_W-1:0]         addr_q, sel_addr;
  logic                    we_q, sel_we;
  logic [3:0]              be_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [WORD_W-DATA_WIDTH-1:0] rbuf;

  logic                    ena_nx, wea_nx, i_ack_nx, d_ack_nx;
  logic [ADDR_WIDTH-1:0]   addra_nx;
  logic [DATA_WIDTH-1:0]   dina_nx;

  bram_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({d_req, i_req}),
    .update     (arb_update),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  // After a grant, last_grant names the port that owns the access in flight.
  assign sel_addr = gnt[1] ? d_addr : i_addr;
  assign sel_we   = gnt[1] & d_we;
  assign k_inc    = k + 1'b1;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    arb_update = 1'b0;
    ena_nx     = 1'b0;
    wea_nx     = 1'b0;
    addra_nx   = '0;
    dina_nx    = '0;
    i_ack_nx   = 1'b0;
    d_ack_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          arb_update = 1'b1;
          state_nx   = XFER;
          k_nx       = '0;
          ena_nx     = 1'b1;
          addra_nx   = {sel_addr, {K_W{1'b0}}};
          wea_nx     = sel_we & d_be[0];
          dina_nx    = sel_we ? d_wdata[DATA_WIDTH-1:0] : '0;
        end
      end
      XFER: begin
        if (k == K_LAST) begin
          state_nx = we_q ? DONE : DRAIN;
          d_ack_nx = we_q;
        end else begin
          k_nx     = k_inc;
          ena_nx   = 1'b1;
          addra_nx = {addr_q, k_inc};
          wea_nx   = we_q & be_q[k_inc];
          dina_nx  = we_q ? wdata_q[{k_inc, 3'b000} +: DATA_WIDTH] : '0;
        end
      end
      DRAIN: begin
        state_nx = DONE;
        i_ack_nx = (last_grant == GNT_INST);
        d_ack_nx = (last_grant == GNT_DATA);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
    end else begin
      state      <= state_nx;
      k          <= k_nx;
      bram_ena   <= ena_nx;
      bram_wea   <= wea_nx;
      bram_addra <= addra_nx;
      bram_dina  <= dina_nx;
      i_ack      <= i_ack_nx;
      d_ack      <= d_ack_nx;
      if (arb_update) begin
        addr_q  <= sel_addr;
        we_q    <= sel_we;
        be_q    <= d_be;
        wdata_q <= d_wdata;
      end
      // douta lags the address by one cycle, so byte k-1 arrives during byte cycle k.
      if (state == XFER) begin
        case (k)
          2'd1:    rbuf[7:0]   <= bram_douta;
          2'd2:    rbuf[15:8]  <= bram_douta;
          2'd3:    rbuf[23:16] <= bram_douta;
          default: ;
        endcase
      end
      if (state == DRAIN) begin
        if (last_grant == GNT_INST) i_rdata <= {bram_douta, rbuf};
        else                        d_rdata <= {bram_douta, rbuf};
      end
    end
  end

endmodule

// File: tb/tb_bram_word_arbiter.sv
// Directed self-checking bench for bram_word_arbiter with a behavioural
// 2048x8 single-port BRAM (1-cycle read latency) attached.
module tb_bram_word_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack;
  logic [8:0]  i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_be;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        busy, bram_ena, bram_wea;
  logic [10:0] bram_addra;
  logic [7:0]  bram_dina, bram_douta;

  logic        mem_clr;
  logic [7:0]  mem [0:2047];

  int          tests = 0;
  int          fails = 0;
  int          lat;
  logic [3:0]  wea_mask;
  logic        saw_top;

  always #5 clk = ~clk;

  bram_word_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .busy       (busy),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_douta (bram_douta)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 2048; a++) mem[a] <= 8'h00;
      bram_douta <= 8'h00;
    end else if (bram_ena) begin
      if (bram_wea) mem[bram_addra] <= bram_dina;
      bram_douta <= mem[bram_addra];
    end
  end

  function automatic logic [31:0] mem_word(input int wa);
    return {mem[4*wa+3], mem[4*wa+2], mem[4*wa+1], mem[4*wa]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until either ack; a timeout shows up as a wrong latency.
  task automatic wait_ack(input int start, output int cyc);
    cyc = start;
    if (start == 0) begin
      wea_mask = 4'b0000;
      saw_top  = 1'b0;
    end
    while (!(d_ack || i_ack) && cyc < 20) begin
      step();
      cyc++;
      if (bram_ena && bram_wea) wea_mask[bram_addra[1:0]] = 1'b1;
      if (bram_ena && bram_addra == 11'd2047) saw_top = 1'b1;
    end
  endtask

  task automatic d_access(input logic we, input logic [3:0] be, input logic [8:0] a,
                          input logic [31:0] wd, output int cyc);
    d_we    = we;
    d_be    = be;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    wait_ack(0, cyc);
    step();
    d_req = 1'b0;
  endtask

  initial begin
    int   n;
    int   acyc [5];
    logic aport [5];
    int   exp_tie [5] = '{60, 131, 200, 271, 340};

    rst = 1'b1; mem_clr = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    step(); step(); step();

    check("rst_ena",   bram_ena,   0);
    check("rst_wea",   bram_wea,   0);
    check("rst_addra", bram_addra, 0);
    check("rst_dina",  bram_dina,  0);
    check("rst_busy",  busy,       0);
    check("rst_i_ack", i_ack,      0);
    check("rst_d_ack", d_ack,      0);
    check("rst_i_rd",  i_rdata,    0);
    check("rst_d_rd",  d_rdata,    0);
    mem_clr = 1'b0;
    rst     = 1'b0;
    step();

    // Full write then read of word 3.
    d_access(1'b1, 4'b1111, 9'd3, 32'hDEADBEEF, lat);
    check("wr_lat", lat, 5);
    check("wr_bytes", mem_word(3), 32'hDEADBEEF);
    d_access(1'b0, 4'b0000, 9'd3, 32'h0, lat);
    check("rd_lat", lat, 6);
    check("rd_data", d_rdata, 32'hDEADBEEF);
    check("rd_i_untouched", i_rdata, 32'h0);

    // Partial write: bytes 0 and 2 only.
    d_access(1'b1, 4'b0101, 9'd3, 32'h11223344, lat);
    check("pw_lat", lat, 5);
    check("pw_wea_mask", wea_mask, 4'b0101);
    d_access(1'b0, 4'b0000, 9'd3, 32'h0, lat);
    check("pw_rd", d_rdata, 32'hDE22BE44);

    // Address-space boundaries.
    d_access(1'b1, 4'b1111, 9'd511, 32'hCAFEF00D, lat);
    check("top_addr_seen", saw_top, 1);
    d_access(1'b1, 4'b1111, 9'd0, 32'h01020304, lat);
    check("bot_bytes", mem_word(0), 32'h01020304);
    check("top_no_alias", mem_word(511), 32'hCAFEF00D);
    d_access(1'b0, 4'b0000, 9'd511, 32'h0, lat);
    check("top_rd", d_rdata, 32'hCAFEF00D);
    d_access(1'b0, 4'b0000, 9'd0, 32'h0, lat);
    check("bot_rd", d_rdata, 32'h01020304);
    check("w3_intact", mem_word(3), 32'hDE22BE44);

    // Both ports requesting continuously: expect I,D,I,D,I at cycles 6,13,20,27,34.
    n = 0;
    for (int j = 0; j < 5; j++) begin
      acyc[j]  = 0;
      aport[j] = 1'b0;
    end
    i_addr = 9'd0;
    d_addr = 9'd511;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      if (i_ack && n < 5) begin aport[n] = 1'b0; acyc[n] = c; n++; end
      if (d_ack && n < 5) begin aport[n] = 1'b1; acyc[n] = c; n++; end
    end
    step();
    i_req = 1'b0;
    d_req = 1'b0;
    check("tie_count", n, 5);
    for (int j = 0; j < 5; j++) check($sformatf("tie_ack%0d", j), acyc[j] * 10 + int'(aport[j]), exp_tie[j]);
    check("tie_i_rd", i_rdata, 32'h01020304);
    check("tie_d_rd", d_rdata, 32'hCAFEF00D);

    // Reset during byte cycle 2 of a write, then automatic retry.
    d_we = 1'b1; d_be = 4'b1111; d_addr = 9'd5; d_wdata = 32'h89ABCDEF;
    d_req = 1'b1;
    step(); step(); step();
    check("mid_addra", bram_addra, 11'd22);
    check("mid_ena", bram_ena, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ena",  bram_ena, 0);
    check("mid_rst_wea",  bram_wea, 0);
    check("mid_rst_busy", busy,     0);
    check("mid_rst_ack",  d_ack,    0);
    step(); step();
    rst = 1'b0;
    wait_ack(0, lat);
    step();
    d_req = 1'b0;
    check("retry_lat", lat, 5);
    d_access(1'b0, 4'b0000, 9'd5, 32'h0, lat);
    check("retry_rd", d_rdata, 32'h89ABCDEF);

    // Back-to-back writes with a new address the cycle after ack.
    d_we = 1'b1; d_be = 4'b1111; d_addr = 9'd7; d_wdata = 32'h0BADF00D;
    d_req = 1'b1;
    wait_ack(0, lat);
    check("b2b_lat0", lat, 5);
    step();
    check("b2b_idle_busy", busy, 0);
    d_addr  = 9'd8;
    d_wdata = 32'h5EED1234;
    step();
    check("b2b_busy", busy, 1);
    check("b2b_addra", bram_addra, 11'd32);
    wait_ack(1, lat);
    check("b2b_lat1", lat, 5);
    step();
    d_req = 1'b0;
    d_access(1'b0, 4'b0000, 9'd7, 32'h0, lat);
    check("b2b_rd7", d_rdata, 32'h0BADF00D);
    d_access(1'b0, 4'b0000, 9'd8, 32'h0, lat);
    check("b2b_rd8", d_rdata, 32'h5EED1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
